baudrate_frac: RTL and testbench
================================

# baudrate_frac

Parametrised fractional-N baud tick generator for the UART path; successor to the fixed-divisor 9600-baud enable generator. From the single system clock it produces a one-cycle receiver oversample enable and a one-cycle transmitter bit enable. The divisor is integer plus fraction, programmable at runtime through a valid/ready handshake, and applied glitch-free on a bit boundary. A receiver resync input re-phases the oversample grid to a detected start edge.

## Interface
- INT_W, 16: width of integer divisor.
- FRAC_W, 4: width of fractional divisor; fraction = cfg_div_frac / 2^FRAC_W.
- OVERSAMPLE, 16: rx ticks per tx tick; must be ≥ 2.
- RESET_DIV_INT, 325: integer divisor after reset (50 MHz / (9600·16) = 325.52).
- RESET_DIV_FRAC, 8: fractional divisor after reset (8/16).
- clk_50m, input, 1: system clock.
- rst_n, input, 1: reset. Synchronous, active-low.
- en, input, 1: generator enable.
- cfg_div_int, input, INT_W: new integer divisor.
- cfg_div_frac, input, FRAC_W: new fractional divisor.
- cfg_valid, input, 1: config request.
- cfg_ready, output, 1: config accepted when high together with cfg_valid.
- rx_resync, input, 1: one-cycle pulse from the receiver on start-edge detect.
- Rxclk_en, output, 1: oversample tick, one cycle wide.
- Txclk_en, output, 1: bit tick, one cycle wide, always coincident with an Rxclk_en.

## Operation
- State:
  - rx_cnt (INT_W) down-counter.
  - facc (FRAC_W) fraction accumulator.
  - os_cnt (0..OVERSAMPLE-1).
  - Active divisor pair, pending divisor pair, and a pending flag.
- Reset (rst_n low at the clock edge):
  - rx_cnt = 0, facc = 0, os_cnt = 0.
  - Active pair = RESET_DIV_INT/RESET_DIV_FRAC; pending flag cleared.
  - Outputs: Rxclk_en = 0, Txclk_en = 0, cfg_ready = 1. Outputs are forced to 0 in every cycle rst_n is low.
- Rx tick: Rxclk_en = rst_n & en & ~rx_resync & (rx_cnt == 0). It is decoded from state with no register stage.
- On an rx tick:
  - Compute {carry, facc'} = facc + div_frac.
  - rx_cnt ← div_int − 1 + carry; facc ← facc'.
  - Resulting period = div_int + carry cycles; the average is div_int + div_frac/2^FRAC_W.
  - Otherwise rx_cnt decrements.
- Effective div_int = max(cfg value, 1). A value of 0 is clamped to 1.
- Tx tick: Txclk_en = Rxclk_en & (os_cnt == 0). On each rx tick, os_cnt ← (os_cnt + 1) mod OVERSAMPLE.
- en low: rx_cnt, facc and os_cnt are cleared to 0 and no ticks are produced. The first cycle en is high again gives Rxclk_en = Txclk_en = 1.
- rx_resync (with en high):
  - rx_cnt ← div_int − 1, facc ← 0, os_cnt ← 0.
  - No tick in that cycle; resync beats a coincident tick.
  - The next rx tick is div_int cycles later and is also a tx tick.
- Config handshake:
  - cfg_valid & cfg_ready captures the pending pair and sets the pending flag; cfg_ready = ~pending.
  - Apply point: the first Txclk_en cycle after capture. In that cycle the reload uses the new pair with facc treated as 0, and active ← pending.
  - If en is low, the pending pair is applied on the cycle after capture.
  - The pending flag clears when the pair is applied, so cfg_ready is high in the next cycle.
  - A request made while pending is held off; cfg_valid is ignored while cfg_ready is low.
- Simultaneous events, in priority order: rst_n, then en low, then rx_resync, then tick/apply.
  - rx_resync in the cycle a pair is pending and en is high: the pair is applied at the resync, and the resync reload uses the new pair.

## Timing
- Latency:
  - en rising to first tick: 0 cycles (same cycle).
  - rx_resync to next tick: div_int cycles.
  - Config capture to effect: up to one tx bit period (≤ OVERSAMPLE·(div_int+1) cycles).
- Arithmetic:
  - The fraction add is FRAC_W+1 bits wide; the carry is the MSB.
  - The reload value fits INT_W, because div_int ≤ 2^INT_W − 1 and reload ≤ div_int.
- Throughput: one config per tx bit period.

## Structure
- Package baud_pkg holds:
  - Default constants: CLK_HZ = 50_000_000, BAUD = 9600, OVERSAMPLE = 16, RESET_DIV_INT, RESET_DIV_FRAC.
  - Function div_clamp(int) for the 0→1 clamp.
- Sub-module baud_frac_div contains rx_cnt, facc, carry and the reload logic, with inputs div_int, div_frac, en, resync.
- The top level adds os_cnt, the config pending/apply logic and the output decode.

## Test plan
- Reset defaults, en = 1 from cycle 0:
  - Rxclk_en at cycles 0, 325, 651, 976, 1302, with intervals alternating 325/326.
  - Txclk_en at cycles 0 and 5208.
- Config int = 2, frac = 15 accepted mid-bit:
  - cfg_ready goes low.
  - The new pair applies at the next Txclk_en.
  - 16 rx ticks then span exactly 47 cycles (15 periods of 3, 1 period of 2).
  - cfg_ready returns high after the apply.
- Second config while pending: cfg_valid is held and not accepted until cfg_ready is high; the first pair is not overwritten.
- rx_resync mid-bit with int = 4, frac = 0:
  - No tick in the resync cycle.
  - Next Rxclk_en and Txclk_en are 4 cycles later; ticks follow every 4 cycles and Txclk_en every 64.
- en low for 100 cycles, then high: no ticks while low; both ticks in the first high cycle.
- Config with en low, then reset:
  - The pair applies next cycle.
  - rst_n low mid-operation clears the outputs and restores 325/8.
- cfg_div_int = 0 is clamped to 1: an Rxclk_en every cycle with frac = 0.

Source files
------------

// File: rtl/baud_pkg.sv
// baud_pkg: default constants and helpers shared by the fractional baud generator
package baud_pkg;
    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD = 9600;
    localparam int OVERSAMPLE = 16;
    localparam int RESET_DIV_INT = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int RESET_DIV_FRAC = ((CLK_HZ * 16) / (BAUD * OVERSAMPLE)) % 16;

    function automatic int div_clamp(input int v);
        return (v < 1) ? 1 : v;
    endfunction
endpackage

// File: rtl/baud_frac_div.sv
// baud_frac_div: integer+fraction down-counter producing the oversample tick
module baud_frac_div #(
    parameter int INT_W = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              en,
    input  logic              resync,
    input  logic              facc_clr,
    input  logic [INT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              tick
);
    logic [INT_W-1:0]  rx_cnt;
    logic [FRAC_W-1:0] facc;
    logic [FRAC_W:0]   sum;
    logic              carry;

    assign tick = rst_n & en & ~resync & (rx_cnt == '0);

    // a fresh divisor pair starts its fraction sequence from zero
    always_comb begin
        sum = {1'b0, (facc_clr ? '0 : facc)} + {1'b0, div_frac};
        carry = sum[FRAC_W];
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n || !en) begin
            rx_cnt <= '0;
            facc <= '0;
        end else if (resync) begin
            rx_cnt <= div_int - INT_W'(1);
            facc <= '0;
        end else if (tick) begin
            rx_cnt <= div_int - INT_W'(!carry);
            facc <= sum[FRAC_W-1:0];
        end else begin
            rx_cnt <= rx_cnt - INT_W'(1);
        end
    end
endmodule

// File: rtl/baudrate_frac.sv
// baudrate_frac: fractional-N rx oversample / tx bit tick generator with runtime divisor
module baudrate_frac #(
    parameter int INT_W = 16,
    parameter int FRAC_W = 4,
    parameter int OVERSAMPLE = baud_pkg::OVERSAMPLE,
    parameter int RESET_DIV_INT = baud_pkg::RESET_DIV_INT,
    parameter int RESET_DIV_FRAC = baud_pkg::RESET_DIV_FRAC
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              en,
    input  logic [INT_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              rx_resync,
    output logic              Rxclk_en,
    output logic              Txclk_en
);
    import baud_pkg::*;

    localparam int OS_W = $clog2(OVERSAMPLE);

    logic [INT_W-1:0]  act_int, pend_int, sel_int;
    logic [FRAC_W-1:0] act_frac, pend_frac, sel_frac;
    logic [OS_W-1:0]   os_cnt;
    logic              pend, rx_tick, apply;

    assign cfg_ready = ~pend;
    assign Rxclk_en = rx_tick;
    assign Txclk_en = rx_tick & (os_cnt == '0);
    // pending pair takes over on a bit boundary, a resync, or at once while idle
    assign apply = pend & (~en | rx_resync | Txclk_en);
    assign sel_int = apply ? pend_int : act_int;
    assign sel_frac = apply ? pend_frac : act_frac;

    baud_frac_div #(.INT_W(INT_W), .FRAC_W(FRAC_W)) u_div (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .en       (en),
        .resync   (rx_resync),
        .facc_clr (apply),
        .div_int  (sel_int),
        .div_frac (sel_frac),
        .tick     (rx_tick)
    );

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            act_int <= INT_W'(RESET_DIV_INT);
            act_frac <= FRAC_W'(RESET_DIV_FRAC);
            pend_int <= INT_W'(RESET_DIV_INT);
            pend_frac <= FRAC_W'(RESET_DIV_FRAC);
            pend <= 1'b0;
            os_cnt <= '0;
        end else begin
            if (cfg_valid && !pend) begin
                pend <= 1'b1;
                pend_int <= INT_W'(div_clamp(int'(cfg_div_int)));
                pend_frac <= cfg_div_frac;
            end else if (apply) begin
                pend <= 1'b0;
                act_int <= pend_int;
                act_frac <= pend_frac;
            end
            os_cnt <= (!en || rx_resync) ? '0 :
                      !rx_tick ? os_cnt :
                      (os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt + OS_W'(1);
        end
    end
endmodule

// File: tb/tb_baudrate_frac.sv
// tb_baudrate_frac: scoreboard bench comparing tick cycles against closed-form schedules
module tb_baudrate_frac;
    logic        clk_50m = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        rx_resync = 1'b0;
    logic [15:0] cfg_div_int = '0;
    logic [3:0]  cfg_div_frac = '0;
    logic        cfg_ready, Rxclk_en, Txclk_en;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          t0, a, b, r, e, f, g, h;

    typedef struct {int c; bit tx;} ev_t;
    ev_t exp_q[$];
    ev_t ev;

    baudrate_frac dut (
        .clk_50m      (clk_50m),
        .rst_n        (rst_n),
        .en           (en),
        .cfg_div_int  (cfg_div_int),
        .cfg_div_frac (cfg_div_frac),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .rx_resync    (rx_resync),
        .Rxclk_en     (Rxclk_en),
        .Txclk_en     (Txclk_en)
    );

    always #10 clk_50m = ~clk_50m;
    always @(posedge clk_50m) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input bit tx);
        exp_q.push_back('{c, tx});
    endtask

    // tick k of a run starting with a zero fraction accumulator
    function automatic int at(input int base, input int k, input int di, input int df);
        return base + k * di + (k * df) / 16;
    endfunction

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk_50m);
            #1;
        end
    endtask

    always @(negedge clk_50m) begin
        if (Rxclk_en) begin
            if (exp_q.size() == 0) check("unexpected_rx", cyc, -1);
            else begin
                ev = exp_q.pop_front();
                check("rx_cycle", cyc, ev.c);
                check("tx_flag", Txclk_en, ev.tx);
            end
        end else if (Txclk_en) check("tx_without_rx", Txclk_en, Rxclk_en);
        if (exp_q.size() != 0 && exp_q[0].c < cyc) begin
            check("missed_rx", cyc, exp_q[0].c);
            exp_q.delete(0);
        end
    end

    initial begin
        wait_cyc(1);
        @(negedge clk_50m);
        check("rst_rx", Rxclk_en, 0);
        check("rst_tx", Txclk_en, 0);
        wait_cyc(3);
        t0 = cyc;
        rst_n = 1'b1;
        for (int k = 0; k <= 16; k++) push(at(t0, k, 325, 8), k % 16 == 0);
        @(negedge clk_50m);
        check("ready_after_rst", cfg_ready, 1);

        a = at(t0, 32, 325, 8);
        b = at(a, 16, 2, 15);
        for (int k = 17; k <= 32; k++) push(at(t0, k, 325, 8), k % 16 == 0);
        for (int j = 1; j <= 16; j++) push(at(a, j, 2, 15), j % 16 == 0);
        for (int m = 1; m <= 20; m++) push(b + 4 * m, m % 16 == 0);
        wait_cyc(t0 + 6208);
        cfg_valid = 1'b1;
        cfg_div_int = 16'd2;
        cfg_div_frac = 4'd15;
        @(negedge clk_50m);
        check("ready_idle", cfg_ready, 1);
        wait_cyc(t0 + 6209);
        cfg_div_int = 16'd4;
        cfg_div_frac = 4'd0;
        @(negedge clk_50m);
        check("ready_pending", cfg_ready, 0);
        for (int n = 0; n < 20000 && !cfg_ready; n++) @(negedge clk_50m);
        check("ready_back_cycle", cyc, a + 1);
        @(posedge clk_50m);
        #1 cfg_valid = 1'b0;

        r = b + 84;
        for (int n = 1; n <= 33; n++) push(r + 4 * n, (n - 1) % 16 == 0);
        wait_cyc(r);
        rx_resync = 1'b1;
        @(negedge clk_50m);
        check("resync_no_tick", Rxclk_en, 0);
        wait_cyc(r + 1);
        rx_resync = 1'b0;

        e = r + 134;
        for (int n = 0; n <= 16; n++) push(e + 100 + 4 * n, n % 16 == 0);
        wait_cyc(e);
        en = 1'b0;
        wait_cyc(e + 100);
        en = 1'b1;

        f = e + 166;
        for (int n = 0; n <= 40; n++) push(f + 3 + n, n % 16 == 0);
        wait_cyc(f);
        en = 1'b0;
        cfg_valid = 1'b1;
        cfg_div_int = 16'd0;
        cfg_div_frac = 4'd0;
        wait_cyc(f + 1);
        cfg_valid = 1'b0;
        @(negedge clk_50m);
        check("ready_en_low_pending", cfg_ready, 0);
        wait_cyc(f + 2);
        @(negedge clk_50m);
        check("ready_en_low_applied", cfg_ready, 1);
        wait_cyc(f + 3);
        en = 1'b1;

        g = f + 44;
        wait_cyc(g);
        rst_n = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk_50m);
            check("mid_rst_rx", Rxclk_en, 0);
            check("mid_rst_tx", Txclk_en, 0);
            wait_cyc(g + i);
        end
        h = cyc;
        rst_n = 1'b1;
        for (int k = 0; k <= 2; k++) push(at(h, k, 325, 8), k == 0);
        @(negedge clk_50m);
        check("ready_after_mid_rst", cfg_ready, 1);
        wait_cyc(h + 653);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
